// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file write-back queue: request payload, grant id, width defaults.
// Pure declarations; no timing or flow control of its own.
package reg_wb_pkg;

    localparam int WB_PW        = 3;
    localparam int WB_AW        = WB_PW + 1;
    localparam int WB_DW        = 8;
    localparam int WB_DEPTH_DEF = 4;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_req_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

    function automatic logic addr_hit(input wb_req_t ent, input logic [WB_AW-1:0] addr);
        return ent.addr == addr;
    endfunction

endpackage

// File: rtl/reg_wb_queue_fifo.sv
// In-order storage of write-back requests; head visible the cycle after push, one push+pop per cycle.
// A push into a full queue is accepted only alongside a pop; entries are exposed oldest-first.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH_DEF,
    localparam int PTRW  = $clog2(DEPTH),
    localparam int CNTW  = PTRW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  wb_req_t                i_dat,
    input  logic                   i_pop,
    output wb_req_t                o_head,
    output logic [CNTW-1:0]        o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output wb_req_t [DEPTH-1:0]    o_ent,
    output logic    [DEPTH-1:0]    o_ent_vld
);

    wb_req_t [DEPTH-1:0] r_mem;
    logic [PTRW-1:0]     r_wptr;
    logic [PTRW-1:0]     r_rptr;
    logic [CNTW-1:0]     r_count;
    logic                w_do_pop;
    logic                w_do_push;

    assign o_count   = r_count;
    assign o_full    = (r_count == CNTW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two; count disambiguates full/empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_dat;
    end

    always_comb begin
        o_ent     = '0;
        o_ent_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_ent[k]     = r_mem[r_rptr + PTRW'(k)];
            o_ent_vld[k] = (CNTW'(k) < r_count);
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Round-robin write-back scheduler A/B -> register file write port; optional forwarding under WB_BYPASS_EN.
// Accepted write reaches rf_* one cycle later; requesters stall while full unless the head drains that cycle.
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter  int PW    = WB_PW,
    parameter  int DW    = WB_DW,
    parameter  int DEPTH = WB_DEPTH_DEF,
    localparam int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_a_valid,
    input  logic [PW:0]     i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    output logic            o_a_ready,
    input  logic            i_b_valid,
    input  logic [PW:0]     i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    output logic            o_b_ready,
    input  logic            i_drain_en,
    output logic            o_rf_wr_en,
    output logic [PW:0]     o_rf_wr_addr,
    output logic [DW-1:0]   o_rf_dat_in,
    input  logic [PW:0]     i_rd_addr_a,
    input  logic [PW:0]     i_rd_addr_b,
    output logic            o_haz_a,
    output logic            o_haz_b,
    output logic [CNTW-1:0] o_count,
    output logic            o_full,
    output logic            o_empty
`ifdef WB_BYPASS_EN
    ,
    output logic            o_fwd_a_valid,
    output logic [DW-1:0]   o_fwd_a_data,
    output logic            o_fwd_b_valid,
    output logic [DW-1:0]   o_fwd_b_data
`endif
);

    grant_t              r_last;
    logic                w_pop;
    logic                w_can_push;
    logic                w_gnt_a;
    logic                w_gnt_b;
    logic                w_push;
    wb_req_t             w_push_dat;
    wb_req_t             w_head;
    wb_req_t [DEPTH-1:0] w_ent;
    logic    [DEPTH-1:0] w_ent_vld;
    logic                w_full;
    logic                w_empty;

    assign w_pop      = i_drain_en & ~w_empty;
    // Gating with rst_n keeps ready low while reset holds the queue, so no handshake is lost.
    assign w_can_push = rst_n & (~w_full | w_pop);
    assign w_gnt_a    = i_a_valid & (~i_b_valid | (r_last == GNT_B));
    assign w_gnt_b    = i_b_valid & (~i_a_valid | (r_last == GNT_A));
    assign w_push     = w_can_push & (w_gnt_a | w_gnt_b);
    assign o_a_ready  = w_can_push & w_gnt_a;
    assign o_b_ready  = w_can_push & w_gnt_b;
    assign w_push_dat = w_gnt_a ? wb_req_t'{addr: i_a_addr, data: i_a_data}
                                : wb_req_t'{addr: i_b_addr, data: i_b_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= GNT_B;
        end else if (w_push) begin
            r_last <= w_gnt_a ? GNT_A : GNT_B;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_dat     (w_push_dat),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (o_count),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ent     (w_ent),
        .o_ent_vld (w_ent_vld)
    );

    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_rf_wr_en   = w_pop;
    assign o_rf_wr_addr = w_head.addr;
    assign o_rf_dat_in  = w_head.data;

    always_comb begin
        o_haz_a = 1'b0;
        o_haz_b = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            o_haz_a = o_haz_a | (w_ent_vld[k] & addr_hit(w_ent[k], i_rd_addr_a));
            o_haz_b = o_haz_b | (w_ent_vld[k] & addr_hit(w_ent[k], i_rd_addr_b));
        end
    end

`ifdef WB_BYPASS_EN
    // Entries are scanned oldest to youngest so the last match (youngest) wins.
    always_comb begin
        o_fwd_a_data = '0;
        o_fwd_b_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_ent_vld[k] && addr_hit(w_ent[k], i_rd_addr_a)) o_fwd_a_data = w_ent[k].data;
            if (w_ent_vld[k] && addr_hit(w_ent[k], i_rd_addr_b)) o_fwd_b_data = w_ent[k].data;
        end
    end

    assign o_fwd_a_valid = o_haz_a;
    assign o_fwd_b_valid = o_haz_b;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_reg_wb_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready;
    logic       drain_en = 1'b0;
    logic       rf_wr_en;
    logic [3:0] rf_wr_addr;
    logic [7:0] rf_dat_in;
    logic [3:0] rd_a = '0, rd_b = '0;
    logic       haz_a, haz_b;
    logic [2:0] count;
    logic       full, empty;
`ifdef WB_BYPASS_EN
    logic       fwd_a_valid, fwd_b_valid;
    logic [7:0] fwd_a_data, fwd_b_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_queue #(.PW(3), .DW(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_a_valid    (a_valid),
        .i_a_addr     (a_addr),
        .i_a_data     (a_data),
        .o_a_ready    (a_ready),
        .i_b_valid    (b_valid),
        .i_b_addr     (b_addr),
        .i_b_data     (b_data),
        .o_b_ready    (b_ready),
        .i_drain_en   (drain_en),
        .o_rf_wr_en   (rf_wr_en),
        .o_rf_wr_addr (rf_wr_addr),
        .o_rf_dat_in  (rf_dat_in),
        .i_rd_addr_a  (rd_a),
        .i_rd_addr_b  (rd_b),
        .o_haz_a      (haz_a),
        .o_haz_b      (haz_b),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty)
`ifdef WB_BYPASS_EN
        ,
        .o_fwd_a_valid (fwd_a_valid),
        .o_fwd_a_data  (fwd_a_data),
        .o_fwd_b_valid (fwd_b_valid),
        .o_fwd_b_data  (fwd_b_data)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_last_b = 1'b1;

    function automatic bit m_haz(input logic [3:0] a);
        foreach (q[i]) if (q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] m_fwd(input logic [3:0] a);
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].addr == a) return q[i].data;
        return 8'h00;
    endfunction

    always @(negedge clk) begin : cmp
        int n;
        bit pop, can, ga, gb, ea, eb;
        if (!rst_n) begin
            q.delete();
            m_last_b = 1'b1;
        end
        n   = q.size();
        pop = drain_en && (n > 0);
        can = rst_n && ((n < DEPTH) || pop);
        ga  = a_valid && (!b_valid || m_last_b);
        gb  = b_valid && (!a_valid || !m_last_b);
        ea  = can && ga;
        eb  = can && gb;
        chk("count", 32'(count), 32'(n));
        chk("count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(pop));
        chk("rf_wr_addr", 32'(rf_wr_addr), (n > 0) ? 32'(q[0].addr) : 32'd0);
        chk("rf_dat_in", 32'(rf_dat_in), (n > 0) ? 32'(q[0].data) : 32'd0);
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        chk("haz_a", 32'(haz_a), 32'(m_haz(rd_a)));
        chk("haz_b", 32'(haz_b), 32'(m_haz(rd_b)));
`ifdef WB_BYPASS_EN
        chk("fwd_a_valid", 32'(fwd_a_valid), 32'(m_haz(rd_a)));
        chk("fwd_b_valid", 32'(fwd_b_valid), 32'(m_haz(rd_b)));
        chk("fwd_a_data", 32'(fwd_a_data), 32'(m_fwd(rd_a)));
        chk("fwd_b_data", 32'(fwd_b_data), 32'(m_fwd(rd_b)));
`endif
        if (rst_n) begin
            if (pop) void'(q.pop_front());
            if (ea) begin
                q.push_back('{a_addr, a_data});
                m_last_b = 1'b0;
            end else if (eb) begin
                q.push_back('{b_addr, b_data});
                m_last_b = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        drain_en = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] gpat;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single write r3=0x5A
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h5A; drain_en = 1'b1;
        #1 chk("t1_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        chk("t1_rf_wr_en", 32'(rf_wr_en), 32'd1);
        chk("t1_rf_wr_addr", 32'(rf_wr_addr), 32'd3);
        chk("t1_rf_dat_in", 32'(rf_dat_in), 32'h5A);
        tick();
        chk("t1_count", 32'(count), 32'd0);

        // both requesters: grants alternate starting with A
        do_reset();
        drain_en = 1'b1;
        gpat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_addr = 4'(k);     a_data = 8'(8'hA0 + k);
            b_valid = 1'b1; b_addr = 4'(8 + k); b_data = 8'(8'hB0 + k);
            #1;
            chk("t2_gnt_a", 32'(a_ready), 32'(gpat[k]));
            chk("t2_gnt_b", 32'(b_ready), 32'(!gpat[k]));
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (5) tick();

        // fill with drain off, then pop+push while full
        do_reset();
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_addr = 4'(k + 1); a_data = 8'(8'h10 + k);
            #1 chk("t3_fill_ready", 32'(a_ready), 32'd1);
            tick();
        end
        a_addr = 4'd5; a_data = 8'h15;
        #1;
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_stall", 32'(a_ready), 32'd0);
        drain_en = 1'b1;
        #1;
        chk("t3_ready_on_pop", 32'(a_ready), 32'd1);
        chk("t3_pop_addr", 32'(rf_wr_addr), 32'd1);
        tick();
        a_valid = 1'b0;
        chk("t3_count_held", 32'(count), 32'd4);
        repeat (6) tick();

        // same-register writes, hazard and forwarding
        do_reset();
        rd_a = 4'd7; rd_b = 4'd3;
        a_valid = 1'b1; a_addr = 4'd7; a_data = 8'h11;
        tick();
        a_data = 8'h22;
        tick();
        a_valid = 1'b0;
        chk("t4_haz_a", 32'(haz_a), 32'd1);
        chk("t4_haz_b", 32'(haz_b), 32'd0);
`ifdef WB_BYPASS_EN
        chk("t4_fwd_a_data", 32'(fwd_a_data), 32'h22);
`endif
        drain_en = 1'b1;
        #1 chk("t4_first_write", 32'(rf_dat_in), 32'h11);
        tick();
        chk("t4_second_write", 32'(rf_dat_in), 32'h22);
        tick();
        chk("t4_drained", 32'(rf_wr_en), 32'd0);
        chk("t4_haz_clear", 32'(haz_a), 32'd0);

        // reset with 3 entries queued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_addr = 4'(k + 9); a_data = 8'(8'h60 + k);
            tick();
        end
        a_valid = 1'b0;
        chk("t5_pre_count", 32'(count), 32'd3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        drain_en = 1'b1;
        #1;
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_empty", 32'(empty), 32'd1);
        chk("t5_rst_wr_en", 32'(rf_wr_en), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_write", 32'(rf_wr_en), 32'd0);
        end

        // wrap-around: 10 push/pop pairs
        do_reset();
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; a_addr = i[3:0]; a_data = 8'(8'h30 + i);
            if (i > 0) chk("t6_order", 32'(rf_dat_in), 32'(8'h30 + i - 1));
            tick();
        end
        a_valid = 1'b0;
        chk("t6_last", 32'(rf_dat_in), 32'h39);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
